gbe_tx_err_counter: RTL and testbench

Counts 10GbE transmit-path errors in the user clock domain and presents them as a single 32-bit status word on `err_count`. `err_count` connects directly to the `user_data_in` port of the `gbe_tx_err_cnt` software register, which makes it readable by the PPC over OPB. The block sits between the GbE core's TX user interface and that register. It watches the transmit handshake, tracks frame boundaries, and counts overflow events and dropped or malformed frames.

---
 rtl/gbe_tx_err_counter.sv | 115 +++++++++++
 tb/tb_gbe_tx_err_counter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbe_tx_err_counter.sv
// 10GbE TX-path error counter: counts tx_overflow rising edges and bad frames,
// packed as {ovf_cnt, frm_cnt} for the gbe_tx_err_cnt software register.
module gbe_tx_err_counter #(
  parameter int SATURATE        = 1,
  parameter int MAX_FRAME_WORDS = 1024
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        tx_valid,
  input  logic        tx_end_of_frame,
  input  logic        tx_overflow,
  input  logic        link_up,
  input  logic        cnt_rst,
  input  logic        cnt_en,
  output logic [31:0] err_count,
  output logic        err_pulse
);

  localparam int                WC_W     = $clog2(MAX_FRAME_WORDS + 2);
  localparam logic [WC_W-1:0]   WC_LIMIT = WC_W'(MAX_FRAME_WORDS);
  localparam logic [WC_W-1:0]   WC_ONE   = WC_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DROP
  } state_t;

  state_t          state, state_next;
  logic [WC_W-1:0] word_cnt, word_cnt_next;
  logic            ovf_q, cnt_rst_q;
  logic [15:0]     ovf_cnt, frm_cnt;
  logic            frm_evt, frame_err;
  logic            ovf_evt, clr;
  logic            last_word;

  assign ovf_evt   = tx_overflow & ~ovf_q;
  assign clr       = cnt_rst & ~cnt_rst_q;
  assign last_word = tx_valid & tx_end_of_frame;
  assign err_count = {ovf_cnt, frm_cnt};

  function automatic logic [15:0] bump(input logic [15:0] c);
    if ((SATURATE != 0) && (c == 16'hFFFF)) return c;
    return c + 16'd1;
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    frm_evt       = 1'b0;
    frame_err     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          word_cnt_next = WC_ONE;
          if (link_up) begin
            state_next = tx_end_of_frame ? IDLE : FRAME;
          end else begin
            frm_evt    = 1'b1;
            state_next = tx_end_of_frame ? IDLE : DROP;
          end
        end
      end
      FRAME: begin
        if (tx_valid) word_cnt_next = word_cnt + WC_ONE;
        // The word that would make the count MAX_FRAME_WORDS+1 is the oversize one.
        frame_err = tx_overflow | ~link_up | (tx_valid & (word_cnt == WC_LIMIT));
        if (frame_err) begin
          frm_evt    = 1'b1;
          state_next = last_word ? IDLE : DROP;
        end else if (last_word) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        if (last_word) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      ovf_q     <= 1'b0;
      cnt_rst_q <= 1'b0;
      ovf_cnt   <= '0;
      frm_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      word_cnt  <= word_cnt_next;
      ovf_q     <= tx_overflow;
      cnt_rst_q <= cnt_rst;
      // Clear wins over a same-cycle increment; that increment is dropped.
      if (clr) begin
        ovf_cnt   <= '0;
        frm_cnt   <= '0;
        err_pulse <= 1'b0;
      end else if (cnt_en) begin
        if (ovf_evt) ovf_cnt <= bump(ovf_cnt);
        if (frm_evt) frm_cnt <= bump(frm_cnt);
        err_pulse <= ovf_evt | frm_evt;
      end else begin
        err_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gbe_tx_err_counter.sv
// Self-checking bench: table vectors, hand sequences for frame corner cases and
// randomized traffic checked against a frame-level reference model.
module tb_gbe_tx_err_counter;

  localparam int MAXW = 1024;

  typedef struct packed {
    logic valid;
    logic eof;
    logic ovf;
    logic link;
    logic crst;
    logic en;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [31:0] exp_count;
    logic        exp_pulse;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_valid, tx_end_of_frame, tx_overflow, link_up, cnt_rst, cnt_en;
  logic [31:0] err_count, err_count_w;
  logic        err_pulse, err_pulse_w;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: frame progress and counters as plain integers
  int m_words;
  bit m_bad;
  bit m_ovf_prev, m_rst_prev;
  int m_ovf[2];
  int m_frm[2];
  bit m_pulse;

  vec_t vecs[0:20];

  always #5 clk = ~clk;

  gbe_tx_err_counter #(.SATURATE(1), .MAX_FRAME_WORDS(MAXW)) dut (
    .user_clk(clk), .user_rst_n(rst_n), .tx_valid(tx_valid),
    .tx_end_of_frame(tx_end_of_frame), .tx_overflow(tx_overflow),
    .link_up(link_up), .cnt_rst(cnt_rst), .cnt_en(cnt_en),
    .err_count(err_count), .err_pulse(err_pulse)
  );

  gbe_tx_err_counter #(.SATURATE(0), .MAX_FRAME_WORDS(MAXW)) dut_w (
    .user_clk(clk), .user_rst_n(rst_n), .tx_valid(tx_valid),
    .tx_end_of_frame(tx_end_of_frame), .tx_overflow(tx_overflow),
    .link_up(link_up), .cnt_rst(cnt_rst), .cnt_en(cnt_en),
    .err_count(err_count_w), .err_pulse(err_pulse_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input in_t in, input logic [31:0] c, input logic p);
    vec_t v;
    v.in = in; v.exp_count = c; v.exp_pulse = p;
    return v;
  endfunction

  function automatic in_t idle_in(input logic ovf, input logic crst);
    in_t i;
    i = '{valid: 1'b0, eof: 1'b0, ovf: ovf, link: 1'b1, crst: crst, en: 1'b1};
    return i;
  endfunction

  function automatic in_t word_in(input logic eof, input logic ovf, input logic link, input logic en);
    in_t i;
    i = '{valid: 1'b1, eof: eof, ovf: ovf, link: link, crst: 1'b0, en: en};
    return i;
  endfunction

  function automatic int inc(input int c, input bit sat);
    if (sat) return (c >= 65535) ? 65535 : c + 1;
    return (c + 1) % 65536;
  endfunction

  task automatic model_reset();
    m_words = 0; m_bad = 0; m_ovf_prev = 0; m_rst_prev = 0; m_pulse = 0;
    for (int k = 0; k < 2; k++) begin m_ovf[k] = 0; m_frm[k] = 0; end
  endtask

  // Applies the counting rules to one sampled set of inputs.
  task automatic model_step(input in_t i);
    bit ovf_edge, clear, frm_event;
    ovf_edge  = i.ovf && !m_ovf_prev;
    clear     = i.crst && !m_rst_prev;
    frm_event = 0;
    if (m_words == 0) begin
      if (i.valid) begin
        m_words = 1;
        m_bad   = 0;
        if (!i.link) begin frm_event = 1; m_bad = 1; end
        if (i.eof) begin m_words = 0; m_bad = 0; end
      end
    end else begin
      if (i.valid) m_words++;
      if (!m_bad && (i.ovf || !i.link || (i.valid && m_words == MAXW + 1))) begin
        frm_event = 1; m_bad = 1;
      end
      if (i.valid && i.eof) begin m_words = 0; m_bad = 0; end
    end
    if (clear) begin
      for (int k = 0; k < 2; k++) begin m_ovf[k] = 0; m_frm[k] = 0; end
      m_pulse = 0;
    end else if (i.en) begin
      for (int k = 0; k < 2; k++) begin
        if (ovf_edge)  m_ovf[k] = inc(m_ovf[k], k == 0);
        if (frm_event) m_frm[k] = inc(m_frm[k], k == 0);
      end
      m_pulse = ovf_edge || frm_event;
    end else begin
      m_pulse = 0;
    end
    m_ovf_prev = i.ovf;
    m_rst_prev = i.crst;
  endtask

  function automatic logic [31:0] model_word(input int k);
    logic [15:0] o, f;
    o = 16'(m_ovf[k]); f = 16'(m_frm[k]);
    return {o, f};
  endfunction

  // One clock: drive, step model, sample #1 after the edge, compare both DUTs.
  task automatic cycle(input in_t i);
    tx_valid = i.valid; tx_end_of_frame = i.eof; tx_overflow = i.ovf;
    link_up = i.link; cnt_rst = i.crst; cnt_en = i.en;
    model_step(i);
    @(posedge clk); #1;
    check("model_count_sat", err_count, model_word(0));
    check("model_pulse_sat", {31'd0, err_pulse}, {31'd0, m_pulse});
    check("model_count_wrap", err_count_w, model_word(1));
    check("model_pulse_wrap", {31'd0, err_pulse_w}, {31'd0, m_pulse});
  endtask

  initial begin
    int pulses;
    in_t r;

    // Overflow-edge vectors (2, 1 and 5 cycle pulses)
    vecs[0]  = mk(idle_in(1, 0), 32'h0001_0000, 1'b1);
    vecs[1]  = mk(idle_in(1, 0), 32'h0001_0000, 1'b0);
    vecs[2]  = mk(idle_in(0, 0), 32'h0001_0000, 1'b0);
    vecs[3]  = mk(idle_in(0, 0), 32'h0001_0000, 1'b0);
    vecs[4]  = mk(idle_in(1, 0), 32'h0002_0000, 1'b1);
    vecs[5]  = mk(idle_in(0, 0), 32'h0002_0000, 1'b0);
    vecs[6]  = mk(idle_in(0, 0), 32'h0002_0000, 1'b0);
    vecs[7]  = mk(idle_in(1, 0), 32'h0003_0000, 1'b1);
    vecs[8]  = mk(idle_in(1, 0), 32'h0003_0000, 1'b0);
    vecs[9]  = mk(idle_in(1, 0), 32'h0003_0000, 1'b0);
    vecs[10] = mk(idle_in(1, 0), 32'h0003_0000, 1'b0);
    vecs[11] = mk(idle_in(1, 0), 32'h0003_0000, 1'b0);
    vecs[12] = mk(idle_in(0, 0), 32'h0003_0000, 1'b0);
    // Clear-priority vectors, starting from 0x00040003
    vecs[13] = mk(idle_in(0, 0), 32'h0004_0003, 1'b0);
    vecs[14] = mk(idle_in(1, 1), 32'h0000_0000, 1'b0);
    vecs[15] = mk(idle_in(0, 1), 32'h0000_0000, 1'b0);
    vecs[16] = mk(idle_in(1, 1), 32'h0001_0000, 1'b1);
    vecs[17] = mk(idle_in(0, 1), 32'h0001_0000, 1'b0);
    vecs[18] = mk(idle_in(0, 0), 32'h0001_0000, 1'b0);
    vecs[19] = mk(idle_in(0, 1), 32'h0000_0000, 1'b0);
    vecs[20] = mk(idle_in(0, 0), 32'h0000_0000, 1'b0);

    // Reset state
    rst_n = 1'b0;
    tx_valid = 0; tx_end_of_frame = 0; tx_overflow = 0; link_up = 1; cnt_rst = 0; cnt_en = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_count", err_count, 32'h0);
    check("reset_pulse", {31'd0, err_pulse}, 32'h0);
    rst_n = 1'b1;

    // Make the count nonzero, then reset mid-frame
    cycle(idle_in(1, 0));
    cycle(idle_in(0, 0));
    check("pre_reset_count", err_count, 32'h0001_0000);
    cycle(word_in(0, 0, 1, 1));
    cycle(word_in(0, 0, 1, 1));
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_count", err_count, 32'h0);
    check("async_reset_pulse", {31'd0, err_pulse}, 32'h0);
    tx_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(word_in(0, 0, 1, 1));
    cycle(word_in(0, 0, 1, 1));
    cycle(word_in(1, 0, 1, 1));
    check("post_reset_frame", err_count, 32'h0);

    // Overflow edges from the table
    pulses = 0;
    for (int k = 0; k <= 12; k++) begin
      cycle(vecs[k].in);
      if (err_pulse) pulses++;
      check($sformatf("ovf_vec%0d_count", k), err_count, vecs[k].exp_count);
      check($sformatf("ovf_vec%0d_pulse", k), {31'd0, err_pulse}, {31'd0, vecs[k].exp_pulse});
    end
    check("ovf_pulse_total", pulses, 3);

    // 10-word frame with tx_overflow high on words 4..7
    pulses = 0;
    for (int w = 1; w <= 10; w++) begin
      cycle(word_in(w == 10, (w >= 4 && w <= 7), 1, 1));
      if (err_pulse) pulses++;
    end
    check("ovf_frame_count", err_count, 32'h0004_0001);
    check("ovf_frame_pulses", pulses, 1);

    // Single-word frame with link down
    cycle(word_in(1, 0, 0, 1));
    check("link_down_frame", err_count, 32'h0004_0002);

    // Exactly MAX_FRAME_WORDS words is legal
    for (int w = 1; w <= MAXW; w++) cycle(word_in(w == MAXW, 0, 1, 1));
    check("max_len_frame", err_count, 32'h0004_0002);

    // One word longer is counted on the last word
    for (int w = 1; w <= MAXW; w++) cycle(word_in(0, 0, 1, 1));
    check("oversize_before", err_count, 32'h0004_0002);
    cycle(word_in(1, 0, 1, 1));
    check("oversize_count", err_count, 32'h0004_0003);
    check("oversize_pulse", {31'd0, err_pulse}, 32'h1);

    // Clear priority from the table
    for (int k = 13; k <= 20; k++) begin
      cycle(vecs[k].in);
      check($sformatf("clr_vec%0d_count", k), err_count, vecs[k].exp_count);
      check($sformatf("clr_vec%0d_pulse", k), {31'd0, err_pulse}, {31'd0, vecs[k].exp_pulse});
    end

    // Enable: five bad frames ignored, one counted
    for (int k = 0; k < 5; k++) cycle(word_in(1, 0, 0, 0));
    check("disabled_count", err_count, 32'h0);
    cycle(word_in(1, 0, 0, 1));
    check("enabled_count", err_count, 32'h0000_0001);

    // Saturation / wrap of frm_cnt
    force dut.frm_cnt = 16'hFFFF;
    force dut_w.frm_cnt = 16'hFFFF;
    #1;
    release dut.frm_cnt;
    release dut_w.frm_cnt;
    m_frm[0] = 65535; m_frm[1] = 65535;
    cycle(word_in(1, 0, 0, 1));
    check("frm_sat_count", err_count, 32'h0000_FFFF);
    check("frm_sat_pulse", {31'd0, err_pulse}, 32'h1);
    check("frm_wrap_count", err_count_w, 32'h0000_0000);

    // Saturation / wrap of ovf_cnt
    force dut.ovf_cnt = 16'hFFFF;
    force dut_w.ovf_cnt = 16'hFFFF;
    #1;
    release dut.ovf_cnt;
    release dut_w.ovf_cnt;
    m_ovf[0] = 65535; m_ovf[1] = 65535;
    cycle(idle_in(1, 0));
    check("ovf_sat_count", err_count, 32'hFFFF_FFFF);
    check("ovf_sat_pulse", {31'd0, err_pulse}, 32'h1);
    check("ovf_wrap_count", err_count_w, 32'h0000_0000);
    cycle(idle_in(0, 1));
    check("clear_after_sat", err_count, 32'h0);
    cycle(idle_in(0, 0));

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r.valid = ($urandom_range(9) < 7);
      r.eof   = ($urandom_range(9) == 0);
      r.ovf   = ($urandom_range(19) == 0) ? ~tx_overflow : tx_overflow;
      r.link  = ($urandom_range(49) != 0);
      r.crst  = ($urandom_range(99) == 0) ? ~cnt_rst : cnt_rst;
      r.en    = ($urandom_range(9) != 0);
      cycle(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
